// File: rtl/eq_pkg.sv
// Shared constants and helpers for the equalizer band generators.
// Defaults here seed the NCO phase accumulator parameters.
package eq_pkg;

    localparam int PHASE_W_DEF = 10;
    localparam int FCW_DEF     = 3;

    localparam logic CFG_FCW = 1'b0;
    localparam logic CFG_OFS = 1'b1;

    function automatic int fcw_for(input longint freq_hz,
                                   input longint clk_hz);
        longint num;
        num = (longint'(1) << PHASE_W_DEF) * freq_hz;
        return int'(num / clk_hz);
    endfunction

endpackage

// File: rtl/phase_acc_lane.sv
// One NCO channel: accumulator, active FCW/offset, registered phase and wrap.
// The offset is applied only on the output path, so it never raises wrap.
module phase_acc_lane
    import eq_pkg::*;
#(
    parameter int PHASE_W     = PHASE_W_DEF,
    parameter int DEFAULT_FCW = FCW_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               sync_clear,
    input  logic               commit,
    input  logic [PHASE_W-1:0] fcw_new,
    input  logic [PHASE_W-1:0] off_new,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap
);

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] fcw_act;
    logic [PHASE_W-1:0] off_act;
    logic               carry_d;
    logic [PHASE_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, fcw_act};

    always_ff @(posedge clock) begin
        if (reset) begin
            acc     <= '0;
            carry_d <= 1'b0;
            fcw_act <= PHASE_W'(DEFAULT_FCW);
            off_act <= '0;
            phase   <= '0;
            wrap    <= 1'b0;
        end else begin
            phase <= acc + off_act;
            wrap  <= carry_d;

            if (commit) begin
                fcw_act <= fcw_new;
                off_act <= off_new;
            end

            // Clear beats enable so a re-alignment never accumulates.
            if (sync_clear) begin
                acc     <= '0;
                carry_d <= 1'b0;
            end else if (enable) begin
                {carry_d, acc} <= sum;
            end else begin
                carry_d <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/phase_accumulator_mc.sv
// Multi-channel NCO phase accumulator with double-buffered FCW/offset.
// Shadow registers live here; commit copies them into every lane at once.
module phase_accumulator_mc
    import eq_pkg::*;
#(
    parameter int PHASE_W     = PHASE_W_DEF,
    parameter int CH          = 4,
    parameter int CH_W        = 2,
    parameter int DEFAULT_FCW = FCW_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cfg_we,
    input  logic                  cfg_sel,
    input  logic [CH_W-1:0]       cfg_addr,
    input  logic [PHASE_W-1:0]    cfg_data,
    input  logic                  commit,
    input  logic [CH-1:0]         sync_clear,
    output logic [CH*PHASE_W-1:0] phase,
    output logic [CH-1:0]         wrap,
    output logic                  commit_ack
);

    logic [PHASE_W-1:0] shadow_fcw [CH];
    logic [PHASE_W-1:0] shadow_off [CH];
    logic               addr_ok;

    assign addr_ok = int'(cfg_addr) < CH;

    // Commit reads the pre-edge shadow, so a same-cycle write lands later.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                shadow_fcw[c] <= PHASE_W'(DEFAULT_FCW);
                shadow_off[c] <= '0;
            end
            commit_ack <= 1'b0;
        end else begin
            commit_ack <= commit;
            if (cfg_we && addr_ok) begin
                unique case (cfg_sel)
                    CFG_FCW: shadow_fcw[cfg_addr] <= cfg_data;
                    CFG_OFS: shadow_off[cfg_addr] <= cfg_data;
                endcase
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        phase_acc_lane #(
            .PHASE_W     (PHASE_W),
            .DEFAULT_FCW (DEFAULT_FCW)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable),
            .sync_clear (sync_clear[c]),
            .commit     (commit),
            .fcw_new    (shadow_fcw[c]),
            .off_new    (shadow_off[c]),
            .phase      (phase[c*PHASE_W +: PHASE_W]),
            .wrap       (wrap[c])
        );
    end

endmodule

// File: tb/tb_phase_accumulator_mc.sv
// Directed bench for phase_accumulator_mc with hand-computed expectations.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_phase_accumulator_mc;

    localparam int PW = 10;
    localparam int CH = 4;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          cfg_we;
    logic          cfg_sel;
    logic [1:0]    cfg_addr;
    logic [PW-1:0] cfg_data;
    logic          commit;
    logic [CH-1:0] sync_clear;
    logic [CH*PW-1:0] phase;
    logic [CH-1:0] wrap;
    logic          commit_ack;

    int checks = 0;
    int errors = 0;

    phase_accumulator_mc #(
        .PHASE_W     (PW),
        .CH          (CH),
        .CH_W        (2),
        .DEFAULT_FCW (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .commit     (commit),
        .sync_clear (sync_clear),
        .phase      (phase),
        .wrap       (wrap),
        .commit_ack (commit_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ph(input int c);
        return 32'(phase[c*PW +: PW]);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [1:0] a,
                      input logic [PW-1:0] d);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = a;
        cfg_data = d;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        cfg_we     = 1'b0;
        cfg_sel    = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        commit     = 1'b0;
        sync_clear = '0;
        step(2);
        reset = 1'b0;

        check("rst_phase", 32'(phase), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_ack", 32'(commit_ack), 0);

        // Default FCW=3 on every channel
        enable = 1'b1;
        step(1); check("t1_p0", ph(0), 0);
        step(1); check("t1_p1", ph(0), 3);
        step(1); check("t1_p2", ph(2), 6);
        step(1); check("t1_p3", ph(3), 9);
        check("t1_wrap", 32'(wrap), 0);

        // Natural modulo wrap: 1020, 1023, 2
        step(337); check("t2_1020", ph(0), 1020);
        check("t2_w1020", 32'(wrap), 0);
        step(1); check("t2_1023", ph(1), 1023);
        check("t2_w1023", 32'(wrap), 0);
        step(1); check("t2_2", ph(0), 2);
        check("t2_w2", 32'(wrap), 4'b1111);
        step(1); check("t2_5", ph(0), 5);
        check("t2_w5", 32'(wrap), 0);

        // Shadow write without commit leaves ch1 at FCW=3
        do_reset();
        enable = 1'b1;
        wr(1'b0, 2'd1, 10);
        step(1);
        cfg_we = 1'b0;
        step(5);
        check("t3_noc", ph(1), 15);
        check("t3_noack", 32'(commit_ack), 0);
        commit = 1'b1;
        step(1);
        check("t3_ack", 32'(commit_ack), 1);
        check("t3_p18", ph(1), 18);
        commit = 1'b0;
        step(1);
        check("t3_ack0", 32'(commit_ack), 0);
        step(1);
        check("t3_c1", ph(1), 31);
        check("t3_c0", ph(0), 24);

        // Offset on ch2; offset overflow is not a wrap
        do_reset();
        wr(1'b1, 2'd2, 512);
        step(1);
        cfg_we = 1'b0;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        step(1);
        check("t4_512", ph(2), 512);
        check("t4_ch0", ph(0), 0);
        wr(1'b0, 2'd2, 600);
        step(1);
        cfg_we = 1'b0;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        step(1);
        check("t4_88", ph(2), 88);
        check("t4_wrap", 32'(wrap), 0);

        // sync_clear beats enable on ch0 only
        enable     = 1'b1;
        sync_clear = 4'b0001;
        step(1);
        enable     = 1'b0;
        sync_clear = '0;
        step(1);
        check("t5_clr0", ph(0), 0);
        check("t5_ch1", ph(1), 6);
        check("t5_ch2", ph(2), 688);
        check("t5_wrap", 32'(wrap), 4'b0100);

        // Same-cycle write + commit takes the old shadow
        wr(1'b0, 2'd3, 7);
        commit = 1'b1;
        step(1);
        cfg_we = 1'b0;
        commit = 1'b0;
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        step(1);
        check("t5_old", ph(3), 9);
        commit = 1'b1;
        step(1);
        check("t5_ackA", 32'(commit_ack), 1);
        step(1);
        check("t5_ackB", 32'(commit_ack), 1);
        commit = 1'b0;
        enable = 1'b1;
        step(1);
        check("t5_ack0", 32'(commit_ack), 0);
        enable = 1'b0;
        step(1);
        check("t5_new", ph(3), 16);

        // Reset discards shadow write; hold freezes phase
        wr(1'b0, 2'd0, 50);
        step(1);
        cfg_we = 1'b0;
        do_reset();
        check("t6_phase", 32'(phase), 0);
        check("t6_wrap", 32'(wrap), 0);
        check("t6_ack", 32'(commit_ack), 0);
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        step(1);
        check("t6_fcw3", ph(0), 6);
        step(3);
        check("t6_hold", ph(0), 6);
        check("t6_hwrap", 32'(wrap), 0);

        check("fcw_for", 32'(eq_pkg::fcw_for(3000, 1000000)), 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
